// File: rtl/pwm_ctrl_pkg.sv
// Shared types and constants for the PWM duty-selection front end.
package pwm_ctrl_pkg;

  localparam int DUTY_WIDTH = 4;

  typedef logic [DUTY_WIDTH-1:0] duty_t;

  localparam duty_t DUTY_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    REPEAT,
    LOCKED
  } duty_sel_state_t;

  // Bits needed for a counter that must be able to hold max_val.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a debounce counter for one raw push-button.
// The debounced level only flips after DEBOUNCE_CYC consecutive synchronized
// samples disagree with it; any agreeing sample restarts the count.
module button_debounce
  import pwm_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = cnt_width(DEBOUNCE_CYC);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Count consecutive disagreeing samples and accept the new level at terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pwm_duty_selector.sv
// Turns up/down push-buttons into the duty code fed directly to the PWM block.
// One step per press, auto-repeat while a single button is held, both buttons
// together lock out stepping until both are released. Duty saturates at 0 and max.
module pwm_duty_selector
  import pwm_ctrl_pkg::*;
#(
  parameter int WIDTH         = DUTY_WIDTH,
  parameter int DEBOUNCE_CYC  = 50000,
  parameter int REPEAT_DELAY  = 5000000,
  parameter int REPEAT_PERIOD = 2500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_down,
  output logic [WIDTH-1:0] value,
  output logic             at_max,
  output logic             at_min,
  output logic             step_pulse
);

  localparam int               RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int               CW   = cnt_width(RMAX);
  localparam logic [WIDTH-1:0] VMAX = {WIDTH{1'b1}};

  logic             u;
  logic             d;
  duty_sel_state_t  state;
  duty_sel_state_t  state_nxt;
  logic             held_up;
  logic             held_up_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             step_inc;
  logic             step_dec;
  logic             held_lvl;
  logic [WIDTH-1:0] value_nxt;
  logic             pulse_nxt;

  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_up),
    .level (u)
  );

  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_down (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_down),
    .level (d)
  );

  // State, held direction and hold/repeat counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      held_up <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      held_up <= held_up_nxt;
      cnt     <= cnt_nxt;
    end
  end

  // Next-state logic and step requests from the debounced button levels.
  always_comb begin
    state_nxt   = state;
    held_up_nxt = held_up;
    cnt_nxt     = cnt;
    step_inc    = 1'b0;
    step_dec    = 1'b0;
    held_lvl    = held_up ? u : d;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (u && d) begin
          state_nxt = LOCKED;
        end else if (u) begin
          step_inc    = 1'b1;
          held_up_nxt = 1'b1;
          state_nxt   = HELD;
        end else if (d) begin
          step_dec    = 1'b1;
          held_up_nxt = 1'b0;
          state_nxt   = HELD;
        end
      end
      HELD: begin
        if (u && d) begin
          state_nxt = LOCKED;
          cnt_nxt   = '0;
        end else if (!held_lvl) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CW'(REPEAT_DELAY - 1)) begin
          step_inc  = held_up;
          step_dec  = !held_up;
          state_nxt = REPEAT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      REPEAT: begin
        if (u && d) begin
          state_nxt = LOCKED;
          cnt_nxt   = '0;
        end else if (!held_lvl) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CW'(REPEAT_PERIOD - 1)) begin
          step_inc = held_up;
          step_dec = !held_up;
          cnt_nxt  = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      LOCKED: begin
        cnt_nxt = '0;
        if (!u && !d) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Apply a requested step unless it would leave the 0..max range.
  always_comb begin
    value_nxt = value;
    pulse_nxt = 1'b0;
    if (step_inc && (value != VMAX)) begin
      value_nxt = value + WIDTH'(1);
      pulse_nxt = 1'b1;
    end else if (step_dec && (value != '0)) begin
      value_nxt = value - WIDTH'(1);
      pulse_nxt = 1'b1;
    end
  end

  // Duty register with flags registered alongside so they always match it.
  always_ff @(posedge clk) begin
    if (rst) begin
      value      <= '0;
      at_max     <= 1'b0;
      at_min     <= 1'b1;
      step_pulse <= 1'b0;
    end else begin
      value      <= value_nxt;
      at_max     <= (value_nxt == VMAX);
      at_min     <= (value_nxt == '0);
      step_pulse <= pulse_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_duty_selector.sv
// Self-checking bench for pwm_duty_selector: a behavioural model predicts each
// duty step and a separate monitor compares it against the DUT's step strobes.
module tb_pwm_duty_selector;

  localparam int DEB     = 4;
  localparam int RDELAY  = 20;
  localparam int RPERIOD = 8;
  localparam int VMAX    = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [3:0] value;
  logic       at_max;
  logic       at_min;
  logic       step_pulse;

  always #5 clk = ~clk;

  pwm_duty_selector #(
    .WIDTH         (4),
    .DEBOUNCE_CYC  (DEB),
    .REPEAT_DELAY  (RDELAY),
    .REPEAT_PERIOD (RPERIOD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .value      (value),
    .at_max     (at_max),
    .at_min     (at_min),
    .step_pulse (step_pulse)
  );

  typedef struct {
    int cycle;
    int val;
  } step_t;

  step_t expQ[$];
  int    checks = 0;
  int    fails = 0;
  int    edgeCount = 0;

  int    mValue = 0;
  int    mLevUp = 0;
  int    mLevDn = 0;
  int    histUp [0:DEB];
  int    histDn [0:DEB];
  int    mDir = 0;
  int    mHeld = 0;
  bit    mLocked = 1'b0;
  bit    lastEdgeReset = 1'b1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edgeCount);
    end
  endtask

  task automatic applyStimulus(input bit up, input bit down, input int cycles);
    btn_up   = up;
    btn_down = down;
    repeat (cycles) @(negedge clk);
  endtask

  // A level flips once the last DEB synchronized samples all disagree with it.
  function automatic int debounced(input int lev, input int h [0:DEB]);
    int flip = 1;
    for (int k = 1; k <= DEB; k++) begin
      if (h[k] == lev) flip = 0;
    end
    return (flip != 0) ? 1 - lev : lev;
  endfunction

  function automatic void stepModel(input int dir);
    if (dir > 0 && mValue < VMAX) begin
      mValue++;
      expQ.push_back('{edgeCount, mValue});
    end else if (dir < 0 && mValue > 0) begin
      mValue--;
      expQ.push_back('{edgeCount, mValue});
    end
  endfunction

  // Reference model: one step on press, a step after RDELAY held cycles, then every RPERIOD.
  initial begin
    int u;
    int d;
    for (int k = 0; k <= DEB; k++) begin
      histUp[k] = 0;
      histDn[k] = 0;
    end
    forever begin
      @(posedge clk);
      edgeCount++;
      if (rst) begin
        lastEdgeReset = 1'b1;
        mValue  = 0;
        mLevUp  = 0;
        mLevDn  = 0;
        mDir    = 0;
        mHeld   = 0;
        mLocked = 1'b0;
        for (int k = 0; k <= DEB; k++) begin
          histUp[k] = 0;
          histDn[k] = 0;
        end
      end else begin
        lastEdgeReset = 1'b0;
        u = mLevUp;
        d = mLevDn;
        if (mLocked) begin
          if (u == 0 && d == 0) mLocked = 1'b0;
        end else if (mDir == 0) begin
          if (u != 0 && d != 0) mLocked = 1'b1;
          else if (u != 0) begin
            mDir = 1; mHeld = 0; stepModel(1);
          end else if (d != 0) begin
            mDir = -1; mHeld = 0; stepModel(-1);
          end
        end else begin
          if (u != 0 && d != 0) begin
            mLocked = 1'b1; mDir = 0;
          end else if ((mDir == 1 && u == 0) || (mDir == -1 && d == 0)) begin
            mDir = 0;
          end else begin
            mHeld++;
            if (mHeld == RDELAY || (mHeld > RDELAY && (mHeld - RDELAY) % RPERIOD == 0))
              stepModel(mDir);
          end
        end
        mLevUp = debounced(mLevUp, histUp);
        mLevDn = debounced(mLevDn, histDn);
        for (int k = DEB; k > 0; k--) begin
          histUp[k] = histUp[k-1];
          histDn[k] = histDn[k-1];
        end
        histUp[0] = int'(btn_up);
        histDn[0] = int'(btn_down);
      end
    end
  end

  // Monitor: pops expected steps on each strobe and checks invariants every cycle.
  initial begin
    step_t e;
    int    prev = 0;
    bit    havePrev = 1'b0;
    forever begin
      @(negedge clk);
      if (edgeCount > 0) begin
        checkOutput("value_track", int'(value), mValue);
        checkOutput("at_max_flag", int'(at_max), (value == 4'd15) ? 1 : 0);
        checkOutput("at_min_flag", int'(at_min), (value == 4'd0) ? 1 : 0);
        if (step_pulse) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_step", 1, 0);
          end else begin
            e = expQ.pop_front();
            checkOutput("step_cycle", edgeCount, e.cycle);
            checkOutput("step_value", int'(value), e.val);
          end
          if (havePrev && !lastEdgeReset) begin
            checkOutput("step_delta", (int'(value) - prev) * (int'(value) - prev), 1);
          end
        end else begin
          if (expQ.size() != 0 && expQ[0].cycle <= edgeCount) begin
            e = expQ.pop_front();
            checkOutput("missing_step", 0, 1);
          end
          if (havePrev && !lastEdgeReset) begin
            checkOutput("silent_change", int'(value), prev);
          end
        end
        prev = int'(value);
        havePrev = 1'b1;
      end
    end
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_value", int'(value), 0);
    checkOutput("reset_at_min", int'(at_min), 1);
    checkOutput("reset_at_max", int'(at_max), 0);
    checkOutput("reset_step_pulse", int'(step_pulse), 0);
    rst = 1'b0;
    applyStimulus(0, 0, 4);

    // Single short press, then a glitch that must be ignored
    applyStimulus(1, 0, 6);
    applyStimulus(0, 0, 20);
    checkOutput("single_press", int'(value), 1);
    applyStimulus(1, 0, 2);
    applyStimulus(0, 0, 20);
    checkOutput("glitch_ignored", int'(value), 1);

    // Long hold up saturates at max
    applyStimulus(1, 0, 200);
    checkOutput("hold_up_max", int'(value), 15);
    checkOutput("hold_up_at_max", int'(at_max), 1);
    applyStimulus(0, 0, 20);

    // Long hold down saturates at zero without wrapping
    applyStimulus(0, 1, 200);
    checkOutput("hold_down_min", int'(value), 0);
    checkOutput("hold_down_at_min", int'(at_min), 1);
    applyStimulus(0, 0, 20);

    // Simultaneous press locks out stepping until both released
    applyStimulus(1, 1, 20);
    checkOutput("locked_both", int'(value), 0);
    applyStimulus(0, 1, 20);
    checkOutput("locked_one_released", int'(value), 0);
    applyStimulus(0, 0, 20);
    applyStimulus(1, 0, 10);
    applyStimulus(0, 0, 20);
    checkOutput("after_lock_press", int'(value), 1);

    // Reset in the middle of auto-repeat with the button still held
    applyStimulus(1, 0, 60);
    checkOutput("repeat_before_reset", int'(value), 7);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_mid_repeat", int'(value), 0);
    rst = 1'b0;
    applyStimulus(1, 0, 6);
    checkOutput("post_reset_no_step_yet", int'(value), 0);
    applyStimulus(1, 0, 4);
    checkOutput("post_reset_fresh_press", int'(value), 1);
    applyStimulus(0, 0, 20);

    // Randomized button activity with occasional resets
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 60)));
    end
    applyStimulus(0, 0, 30);
    checkOutput("queue_drained", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
